// File: rtl/dcache_pkg.sv
// Shared types, funct3 codes and geometry helpers for the direct-mapped data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRefill,
    StWrite,
    StDone
  } state_e;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  function automatic int unsigned index_bits(input int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned word_bits(input int unsigned words);
    return $clog2(words);
  endfunction

  function automatic int unsigned tag_bits(input int unsigned sets, input int unsigned words);
    return 32 - 2 - $clog2(sets) - $clog2(words);
  endfunction

endpackage

// File: rtl/dcache_align.sv
// Load byte/halfword extraction with extension, and store lane steering with byte strobes.
module dcache_align
  import dcache_pkg::*;
(
  input  logic [2:0]  mem_ctrl,
  input  logic [1:0]  offset,
  input  logic [31:0] load_word,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] store_wdata,
  output logic [3:0]  store_wstrb
);

  logic [31:0] byte_shift;
  logic [31:0] half_shift;

  always_comb begin
    byte_shift = load_word >> {offset, 3'b000};
    half_shift = load_word >> {offset[1], 4'b0000};
    case (mem_ctrl)
      LB:      load_data = {{24{byte_shift[7]}}, byte_shift[7:0]};
      LH:      load_data = {{16{half_shift[15]}}, half_shift[15:0]};
      LBU:     load_data = {24'b0, byte_shift[7:0]};
      LHU:     load_data = {16'b0, half_shift[15:0]};
      default: load_data = load_word;
    endcase
  end

  // Stores only distinguish SB/SH; every other code is a full word.
  always_comb begin
    case (mem_ctrl)
      LB: begin
        store_wdata = {24'b0, store_data[7:0]} << {offset, 3'b000};
        store_wstrb = 4'b0001 << offset;
      end
      LH: begin
        store_wdata = {16'b0, store_data[15:0]} << {offset[1], 4'b0000};
        store_wstrb = offset[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        store_wdata = store_data;
        store_wstrb = 4'b1111;
      end
    endcase
  end

endmodule

// File: rtl/dcache.sv
// Direct-mapped write-through, no-write-allocate data cache for the memory stage.
// Define DCACHE_PERF_CNT_EN to build the hit/miss performance counters.
module dcache
  import dcache_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned SETS           = 16,
  parameter int unsigned WORDS_PER_LINE = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [2:0]            mem_ctrl_i,
  input  logic [31:0]           addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  stall_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [31:0]           mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [3:0]            mem_wstrb_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_ack_i,
  output logic [31:0]           hit_count_o,
  output logic [31:0]           miss_count_o
);

  localparam int unsigned IdxW  = index_bits(SETS);
  localparam int unsigned WordW = word_bits(WORDS_PER_LINE);
  localparam int unsigned TagW  = tag_bits(SETS, WORDS_PER_LINE);

  state_e             state_q, state_d;
  logic [WordW-1:0]   beat_q, beat_d;
  logic [SETS-1:0]    valid_q;
  logic [TagW-1:0]    tag_q  [SETS];
  logic [DATA_WIDTH-1:0] data_q [SETS*WORDS_PER_LINE];

  logic [IdxW-1:0]  idx;
  logic [WordW-1:0] word;
  logic [TagW-1:0]  tag;
  logic             tag_hit;
  logic             load_hit;
  logic [31:0]      load_data;
  logic [31:0]      store_wdata;
  logic [3:0]       store_wstrb;
  logic             refill_we;
  logic             line_done;
  logic             merge_we;

  assign idx      = addr_i[WordW+2 +: IdxW];
  assign word     = addr_i[2 +: WordW];
  assign tag      = addr_i[31 -: TagW];
  assign tag_hit  = valid_q[idx] && (tag_q[idx] == tag);
  assign load_hit = req_i && !we_i && tag_hit;

  dcache_align u_align (
    .mem_ctrl    (mem_ctrl_i),
    .offset      (addr_i[1:0]),
    .load_word   (data_q[{idx, word}]),
    .store_data  (wdata_i),
    .load_data   (load_data),
    .store_wdata (store_wdata),
    .store_wstrb (store_wstrb)
  );

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    refill_we   = 1'b0;
    line_done   = 1'b0;
    merge_we    = 1'b0;
    stall_o     = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wstrb_o = '0;
    rdata_o     = '0;
    unique case (state_q)
      StIdle: begin
        if (req_i) begin
          if (we_i) begin
            stall_o = 1'b1;
            state_d = StWrite;
          end else if (tag_hit) begin
            rdata_o = load_data;
          end else begin
            stall_o = 1'b1;
            beat_d  = '0;
            state_d = StRefill;
          end
        end
      end
      StRefill: begin
        stall_o    = 1'b1;
        mem_req_o  = 1'b1;
        mem_addr_o = {tag, idx, beat_q, 2'b00};
        if (mem_ack_i) begin
          refill_we = 1'b1;
          if (beat_q == WordW'(WORDS_PER_LINE - 1)) begin
            line_done = 1'b1;
            beat_d    = '0;
            state_d   = StDone;
          end else begin
            beat_d = beat_q + WordW'(1);
          end
        end
      end
      StWrite: begin
        stall_o     = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {addr_i[31:2], 2'b00};
        mem_wdata_o = store_wdata;
        mem_wstrb_o = store_wstrb;
        if (mem_ack_i) begin
          merge_we = tag_hit;
          state_d  = StDone;
        end
      end
      StDone: begin
        if (!we_i) rdata_o = load_data;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      beat_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      if (line_done) valid_q[idx] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; valid_q alone qualifies them.
  always_ff @(posedge clk) begin
    if (refill_we) data_q[{idx, beat_q}] <= mem_rdata_i;
    if (line_done) tag_q[idx] <= tag;
    for (int b = 0; b < 4; b++) begin
      if (merge_we && store_wstrb[b]) data_q[{idx, word}][8*b +: 8] <= store_wdata[8*b +: 8];
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hit_q, miss_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (state_q == StIdle) begin
      if (load_hit) hit_q <= hit_q + 32'd1;
      if (req_i && !we_i && !tag_hit) miss_q <= miss_q + 32'd1;
    end
  end

  assign hit_count_o  = hit_q;
  assign miss_count_o = miss_q;
`else
  assign hit_count_o  = '0;
  assign miss_count_o = '0;
`endif

endmodule

// File: tb/tb_dcache.sv
// Scoreboard bench for dcache: driver pushes model expectations, monitors compare DUT outputs.
module tb_dcache;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [2:0]  mem_ctrl_i = 3'b0;
  logic [31:0] addr_i = 32'b0;
  logic [31:0] wdata_i = 32'b0;
  logic [31:0] rdata_o;
  logic        stall_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;
  logic [31:0] hit_count_o;
  logic [31:0] miss_count_o;

  always #5 clk = ~clk;

  dcache u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req_i),
    .we_i         (we_i),
    .mem_ctrl_i   (mem_ctrl_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .rdata_o      (rdata_o),
    .stall_o      (stall_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_wstrb_o  (mem_wstrb_o),
    .mem_rdata_i  (mem_rdata_i),
    .mem_ack_i    (mem_ack_i),
    .hit_count_o  (hit_count_o),
    .miss_count_o (miss_count_o)
  );

  typedef struct {
    bit          is_load;
    logic [31:0] rdata;
    int          stalls;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  exp_t        exp_q[$];
  wr_t         wr_q[$];
  logic [31:0] refill_q[$];

  logic [31:0] back_mem [1024];
  logic [31:0] ref_mem  [1024];
  bit          mvalid   [16];
  int unsigned mtag     [16];
  int          hits_m = 0;
  int          misses_m = 0;

  int n_vec = 0;
  int n_err = 0;
  int lat = 0;
  int wait_cnt = 0;
  int wait_nxt = 0;
  int cyc = 0;

  assign mem_ack_i   = mem_req_o && (wait_cnt == lat);
  assign mem_rdata_i = back_mem[mem_addr_o[11:2]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic finish_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  endtask

  function automatic logic [31:0] exp_hit_cnt();
`ifdef DCACHE_PERF_CNT_EN
    return hits_m;
`else
    return 0;
`endif
  endfunction

  function automatic logic [31:0] exp_miss_cnt();
`ifdef DCACHE_PERF_CNT_EN
    return misses_m;
`else
    return 0;
`endif
  endfunction

  // Backing memory: checks every request cycle against the expected beat, merges on write ack.
  always @(negedge clk) begin
    if (!rst_n) begin
      refill_q.delete();
      wr_q.delete();
      wait_nxt = 0;
    end else begin
      if (mem_req_o && mem_we_o) begin
        if (wr_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_write: got addr %h, expected no write", mem_addr_o);
        end else begin
          check("wr_addr", mem_addr_o, wr_q[0].addr);
          check("wr_data", mem_wdata_o, wr_q[0].data);
          check("wr_strb", {28'b0, mem_wstrb_o}, {28'b0, wr_q[0].strb});
          if (mem_ack_i) begin
            for (int b = 0; b < 4; b++)
              if (mem_wstrb_o[b]) back_mem[mem_addr_o[11:2]][8*b +: 8] = mem_wdata_o[8*b +: 8];
            void'(wr_q.pop_front());
          end
        end
      end else if (mem_req_o) begin
        if (refill_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_refill: got addr %h, expected no refill", mem_addr_o);
        end else begin
          check("refill_addr", mem_addr_o, refill_q[0]);
          if (mem_ack_i) void'(refill_q.pop_front());
        end
      end
      wait_nxt = (mem_req_o && !mem_ack_i) ? wait_cnt + 1 : 0;
    end
  end

  always @(posedge clk) wait_cnt <= wait_nxt;

  // Completion monitor: an access completes on the first sampled cycle without stall.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      cyc = 0;
    end else if (req_i) begin
      if (stall_o) begin
        cyc++;
      end else begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_completion: got rdata %h, expected none", rdata_o);
        end else begin
          e = exp_q.pop_front();
          check("stall_cycles", cyc, e.stalls);
          if (e.is_load) check("load_rdata", rdata_o, e.rdata);
        end
        cyc = 0;
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mvalid[i] = 0;
    hits_m   = 0;
    misses_m = 0;
  endtask

  task automatic access(input bit we, input logic [2:0] ctrl, input logic [31:0] a,
                        input logic [31:0] d);
    exp_t        e;
    wr_t         w;
    int unsigned wa, sh, hs, idx, tg, x;
    logic [31:0] word, wd;
    logic [3:0]  strb;
    bit          done;
    wa   = a[11:2];
    word = ref_mem[wa];
    sh   = 8 * a[1:0];
    hs   = a[1] ? 16 : 0;
    idx  = (a / 16) % 16;
    tg   = a / 256;
    e.is_load = !we;
    e.rdata   = 0;
    if (!we) begin
      case (ctrl)
        3'b000: begin x = (word >> sh) % 256;   e.rdata = (x >= 128) ? x + 32'hFFFFFF00 : x; end
        3'b001: begin x = (word >> hs) % 65536; e.rdata = (x >= 32768) ? x + 32'hFFFF0000 : x; end
        3'b100: e.rdata = (word >> sh) % 256;
        3'b101: e.rdata = (word >> hs) % 65536;
        default: e.rdata = word;
      endcase
      if (mvalid[idx] && mtag[idx] == tg) begin
        e.stalls = 0;
        hits_m++;
      end else begin
        e.stalls = 1 + 4 * (lat + 1);
        misses_m++;
        mvalid[idx] = 1;
        mtag[idx]   = tg;
        for (int i = 0; i < 4; i++) refill_q.push_back((a / 16) * 16 + 4 * i);
      end
    end else begin
      case (ctrl)
        3'b000: begin strb = 4'b0001 << a[1:0]; wd = (d % 256) << sh; end
        3'b001: begin strb = a[1] ? 4'b1100 : 4'b0011; wd = (d % 65536) << hs; end
        default: begin strb = 4'b1111; wd = d; end
      endcase
      for (int b = 0; b < 4; b++) if (strb[b]) ref_mem[wa][8*b +: 8] = wd[8*b +: 8];
      w.addr = (a / 4) * 4;
      w.data = wd;
      w.strb = strb;
      wr_q.push_back(w);
      e.stalls = 2 + lat;
    end
    exp_q.push_back(e);
    req_i      = 1'b1;
    we_i       = we;
    mem_ctrl_i = ctrl;
    addr_i     = a;
    wdata_i    = d;
    done       = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!stall_o) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL access_timeout: got stall still high at addr %h, expected completion", a);
      finish_run();
    end
    @(posedge clk);
    #1;
    req_i = 1'b0;
  endtask

  initial begin
    bit found;
    for (int i = 0; i < 1024; i++) begin
      back_mem[i] = $urandom;
      ref_mem[i]  = back_mem[i];
    end
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_stall", {31'b0, stall_o}, 0);
    check("rst_mem_req", {31'b0, mem_req_o}, 0);
    check("rst_mem_we", {31'b0, mem_we_o}, 0);
    check("rst_wstrb", {28'b0, mem_wstrb_o}, 0);
    check("rst_mem_addr", mem_addr_o, 0);
    check("rst_mem_wdata", mem_wdata_o, 0);
    check("rst_rdata", rdata_o, 0);
    check("rst_hits", hit_count_o, 0);
    check("rst_misses", miss_count_o, 0);
    @(posedge clk);
    #1;

    lat = 0;
    access(0, 3'b010, 32'h100, 0);
    access(0, 3'b010, 32'h108, 0);
    access(1, 3'b000, 32'h101, 32'h000000AB);
    access(0, 3'b100, 32'h101, 0);
    access(0, 3'b000, 32'h101, 0);
    access(0, 3'b001, 32'h100, 0);
    access(1, 3'b010, 32'h300, 32'hDEADBEEF);
    access(0, 3'b010, 32'h300, 0);
    lat = 2;
    access(0, 3'b010, 32'h100, 0);
    lat = 0;
    access(0, 3'b010, 32'h200, 0);
    check("hits_mid", hit_count_o, exp_hit_cnt());
    check("misses_mid", miss_count_o, exp_miss_cnt());

    // Reset pulse during the third refill beat of LW 0x100.
    lat = 1;
    for (int i = 0; i < 4; i++) refill_q.push_back(32'h100 + 4 * i);
    req_i      = 1'b1;
    we_i       = 1'b0;
    mem_ctrl_i = 3'b010;
    addr_i     = 32'h100;
    found      = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (mem_req_o && mem_addr_o == 32'h108) begin
        found = 1;
        break;
      end
    end
    if (!found) begin
      n_vec++;
      n_err++;
      $display("FAIL third_beat_timeout: got no beat at 0x108, expected one");
      finish_run();
    end
    #2;
    rst_n = 1'b0;
    req_i = 1'b0;
    model_reset();
    #1;
    check("rstmid_mem_req", {31'b0, mem_req_o}, 0);
    check("rstmid_stall", {31'b0, stall_o}, 0);
    check("rstmid_hits", hit_count_o, 0);
    check("rstmid_misses", miss_count_o, 0);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    lat = 0;
    access(0, 3'b010, 32'h100, 0);
    access(0, 3'b010, 32'h200, 0);
    access(0, 3'b010, 32'h100, 0);
    check("conflict_misses", miss_count_o, exp_miss_cnt());
    check("conflict_hits", hit_count_o, exp_hit_cnt());

    for (int i = 0; i < 400; i++) begin
      lat = $urandom_range(0, 2);
      access(($urandom % 3) == 0, 3'($urandom % 8), $urandom % 4096, $urandom);
    end

    repeat (3) @(posedge clk);
    check("final_hits", hit_count_o, exp_hit_cnt());
    check("final_misses", miss_count_o, exp_miss_cnt());
    check("exp_q_drained", exp_q.size(), 0);
    check("refill_q_drained", refill_q.size(), 0);
    check("wr_q_drained", wr_q.size(), 0);
    finish_run();
  end

endmodule
